// File: rtl/alu_sched_pkg.sv
// Shared definitions for the two-requester ALU scheduler: opcodes, FSM states
// and the per-opcode latency lookup.
package alu_sched_pkg;

    localparam logic [4:0] OP_ADD       = 5'b00000;
    localparam logic [4:0] OP_SUB       = 5'b00001;
    localparam logic [4:0] OP_MUL       = 5'b00010;
    localparam logic [4:0] OP_DIV       = 5'b00011;
    localparam logic [4:0] OP_MOD       = 5'b00100;
    localparam logic [4:0] OP_CMP       = 5'b00101;
    localparam logic [4:0] OP_AND       = 5'b00110;
    localparam logic [4:0] OP_OR        = 5'b00111;
    localparam logic [4:0] OP_XOR       = 5'b01000;
    localparam logic [4:0] OP_NOR       = 5'b01001;
    localparam logic [4:0] OP_SHL       = 5'b01010;
    localparam logic [4:0] OP_SHR       = 5'b01011;
    localparam logic [4:0] OP_ASR       = 5'b01100;
    localparam logic [4:0] OP_FIRST_BAD = 5'b01101;

    localparam int DEF_MUL_CYCLES = 2;
    localparam int DEF_DIV_CYCLES = 8;
    localparam int CNT_W          = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    function automatic logic op_is_bad(input logic [4:0] op);
        return (op >= OP_FIRST_BAD);
    endfunction

    function automatic logic op_is_div(input logic [4:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

    // Number of EXEC cycles an opcode occupies; unknown opcodes finish in one.
    function automatic logic [CNT_W-1:0] op_latency(input logic [4:0] op,
                                                    input int mul_c,
                                                    input int div_c);
        logic [CNT_W-1:0] lat;
        case (op)
            OP_MUL:         lat = CNT_W'(mul_c);
            OP_DIV, OP_MOD: lat = CNT_W'(div_c);
            default:        lat = CNT_W'(1);
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/alu_sched_rr_arb2.sv
// Two-way round-robin arbiter. The last_grant register only moves when the
// winning request is actually accepted.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       gnt_valid,
    output logic       gnt_id
);

    logic last_grant_r;

    // Grant selection: on contention, favour the side not served last.
    always_comb begin
        gnt_valid = |req;
        if (req == 2'b11) begin
            gnt_id = ~last_grant_r;
        end else if (req[1]) begin
            gnt_id = 1'b1;
        end else begin
            gnt_id = 1'b0;
        end
    end

    // Fairness history; resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_r <= 1'b1;
        end else if (advance) begin
            last_grant_r <= gnt_id;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/alu_sched.sv
// Schedules operations from two requesters onto one shared external ALU,
// one operation in flight, with per-opcode multi-cycle latency.
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic [4:0]  alu_signal,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic [1:0]  alu_flags,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_result,
    output logic [1:0]  resp_flags,
    output logic        resp_err,
    output logic        busy
);

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [1:0]         flags_r;
    logic               id_r;
    logic [4:0]         alu_signal_r;
    logic [31:0]        alu_a_r;
    logic [31:0]        alu_b_r;
    logic               resp_valid_r;
    logic               resp_id_r;
    logic [31:0]        resp_result_r;
    logic [1:0]         resp_flags_r;
    logic               resp_err_r;

    logic               gnt_valid_s;
    logic               gnt_id_s;
    logic               accept_s;
    logic [4:0]         sel_op_s;
    logic [31:0]        sel_a_s;
    logic [31:0]        sel_b_s;
    logic [31:0]        cap_result_s;
    logic               cap_err_s;
    logic [1:0]         cap_flags_s;

    rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       ({req1_valid, req0_valid}),
        .advance   (accept_s),
        .gnt_valid (gnt_valid_s),
        .gnt_id    (gnt_id_s)
    );

    // Ready is offered only in IDLE and never while reset is high.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!reset && (state_r == ST_IDLE) && gnt_valid_s) begin
            req0_ready = ~gnt_id_s;
            req1_ready = gnt_id_s;
        end else begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
    end

    assign accept_s = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    // Operand mux toward the granted requester.
    always_comb begin
        if (gnt_id_s) begin
            sel_op_s = req1_op;
            sel_a_s  = req1_a;
            sel_b_s  = req1_b;
        end else begin
            sel_op_s = req0_op;
            sel_a_s  = req0_a;
            sel_b_s  = req0_b;
        end
    end

    // Response formation at the final EXEC edge; div-by-zero overrides the ALU.
    always_comb begin
        cap_result_s = alu_result;
        cap_err_s    = 1'b0;
        cap_flags_s  = flags_r;
        if (op_is_bad(alu_signal_r)) begin
            cap_result_s = 32'd0;
            cap_err_s    = 1'b1;
            cap_flags_s  = 2'b00;
        end else if (op_is_div(alu_signal_r) && (alu_b_r == 32'd0)) begin
            cap_result_s = 32'hFFFF_FFFF;
            cap_err_s    = 1'b1;
        end else if (alu_signal_r == OP_CMP) begin
            cap_result_s = 32'd0;
            cap_flags_s  = alu_flags;
        end else begin
            cap_result_s = alu_result;
            cap_err_s    = 1'b0;
        end
    end

    // Main FSM. The alu_* registers double as the latched operation so the
    // shared ALU sees only stable values during EXEC and zeros otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            cnt_r         <= '0;
            flags_r       <= 2'b00;
            id_r          <= 1'b0;
            alu_signal_r  <= 5'd0;
            alu_a_r       <= 32'd0;
            alu_b_r       <= 32'd0;
            resp_valid_r  <= 1'b0;
            resp_id_r     <= 1'b0;
            resp_result_r <= 32'd0;
            resp_flags_r  <= 2'b00;
            resp_err_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        alu_signal_r <= sel_op_s;
                        alu_a_r      <= sel_a_s;
                        alu_b_r      <= sel_b_s;
                        id_r         <= gnt_id_s;
                        cnt_r        <= op_latency(sel_op_s, MUL_CYCLES, DIV_CYCLES) - CNT_W'(1);
                        state_r      <= ST_EXEC;
                    end else begin
                        state_r      <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    if (cnt_r == '0) begin
                        flags_r       <= cap_flags_s;
                        resp_valid_r  <= 1'b1;
                        resp_id_r     <= id_r;
                        resp_result_r <= cap_result_s;
                        resp_flags_r  <= cap_flags_s;
                        resp_err_r    <= cap_err_s;
                        alu_signal_r  <= 5'd0;
                        alu_a_r       <= 32'd0;
                        alu_b_r       <= 32'd0;
                        state_r       <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_r  <= 1'b0;
                        resp_id_r     <= 1'b0;
                        resp_result_r <= 32'd0;
                        resp_flags_r  <= 2'b00;
                        resp_err_r    <= 1'b0;
                        state_r       <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    resp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign alu_signal  = alu_signal_r;
    assign alu_a       = alu_a_r;
    assign alu_b       = alu_b_r;
    assign resp_valid  = resp_valid_r;
    assign resp_id     = resp_id_r;
    assign resp_result = resp_result_r;
    assign resp_flags  = resp_flags_r;
    assign resp_err    = resp_err_r;
    assign busy        = (state_r != ST_IDLE);

endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 Parameter MUL_CYCLES, default 2, EXEC-cycle count for mul (5'b00010).
REQ-002 Parameter DIV_CYCLES, default 8, EXEC-cycle count for div/mod (5'b00011, 5'b00100); all other ops use 1.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req0_valid/req1_valid  in  1  requester n presents an operation.
REQ-006 req0_ready/req1_ready  out  1  requester n accepted this cycle when valid&ready.
REQ-007 req0_op/req1_op  in  5  ALU opcode; req0_a/req1_a, req0_b/req1_b  in  32  operands.
REQ-008 alu_signal  out  5; alu_a, alu_b  out  32  drive to the shared ALU instance.
REQ-009 alu_result  in  32; alu_flags  in  2  combinational ALU outputs.
REQ-010 resp_valid  out  1; resp_ready  in  1  response handshake.
REQ-011 resp_id  out  1  requester index; resp_result  out  32; resp_flags  out  2; resp_err  out  1.
REQ-012 busy  out  1  high whenever state != IDLE.

Function
REQ-013 FSM states IDLE, EXEC, RESP; one operation in flight at a time.
REQ-014 IDLE: grant = round-robin over valid requesters; reqN_ready = (state==IDLE) & grant==N; ready combinational from valid.
REQ-015 Both valid: grant the requester not granted last; last_grant resets to 1 so req0 wins first contention.
REQ-016 On accept edge: latch op, a, b, id into registers; load cnt = latency-1; go EXEC.
REQ-017 EXEC: alu_signal/alu_a/alu_b driven from latched registers only; outside EXEC drive 0.
REQ-018 EXEC: cnt decrements each cycle; at edge with cnt==0 capture result, go RESP.
REQ-019 Latency: accept at edge k -> resp_valid high after edge k+L (L=1 simple, MUL_CYCLES, DIV_CYCLES).
REQ-020 RESP: resp_valid=1, all resp_* stable until resp_valid&resp_ready; then IDLE next edge; no accept in the RESP cycle.
REQ-021 Flags register updated only by cmp (5'b00101) from alu_flags; other valid ops leave it unchanged; resp_flags = flags register after capture.
REQ-022 cmp: resp_result = 0.
REQ-023 Opcodes 5'b01101..5'b11111: resp_result=0, flags register cleared, resp_err=1, latency 1.
REQ-024 div/mod with latched b==0: resp_result=32'hFFFF_FFFF, resp_err=1, flags unchanged, full DIV_CYCLES latency.
REQ-025 All other cases resp_err=0; resp_result = alu_result sampled at final EXEC edge.
REQ-026 Requester dropping valid while not granted: no effect; operands of a granted request need not be held after accept.

Reset
REQ-027 reset: state=IDLE, cnt=0, last_grant=1, flags=0, all outputs 0 (resp_valid, req*_ready recomputed low during reset).
REQ-028 reset mid-EXEC or mid-RESP aborts the operation; response discarded, never presented.
REQ-029 reqN_ready held 0 while reset is high.

Structure
REQ-030 Package alu_sched_pkg: opcode constants (ADD..ASR, CMP), state enum, default latency constants, latency-lookup function.
REQ-031 Sub-module rr_arb2 (2-way round-robin arbiter with last_grant register); ALU instantiated outside this block.

Verification
REQ-032 req0 add a=5,b=7 accepted edge k -> resp_valid after edge k+1, result=12, id=0, err=0.
REQ-033 req0 and req1 valid together, both held -> grants 0,1,0,1 in order; 4 responses with matching ids.
REQ-034 mul a=3,b=-4 (MUL_CYCLES=2) -> resp_valid after edge k+2, result=32'hFFFF_FFF4; resp_ready low 3 cycles -> outputs stable.
REQ-035 cmp a=9,b=9 -> flags=2'b01; following add 1+1 -> result=2, flags still 2'b01; div 10/0 -> result=32'hFFFF_FFFF, err=1 after 8 EXEC cycles.
REQ-036 reset asserted in 4th EXEC cycle of div -> next cycle IDLE, resp_valid=0, flags=0, req0 wins next contention.
